// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: byte FIFO, self-generated PS/2 clock, odd-parity 11-bit frames, yields to host inhibit.
// Define PS2DEV_RETRY_EN to resend an aborted byte from its start bit ahead of the remaining FIFO contents.
module ps2_device_tx #(
  parameter int HALF_PERIOD = 1120,
  parameter int IDLE_CYCLES = 1400,
  parameter int FIFO_AW     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       dataload,
  inout  wire        ps2clk_ext,
  inout  wire        ps2data_ext,
  output logic       busy,
  output logic       fifo_full,
  output logic       sent,
  output logic       aborted,
  output logic       overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int IW    = $clog2(IDLE_CYCLES + 1);
  localparam logic [PW-1:0]      PH_LAST   = PW'(HALF_PERIOD - 1);
  localparam logic [IW-1:0]      IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAITBUS, HIGH, LOW} state_t;

  state_t             state;
  logic [1:0]         clk_sync;
  logic [1:0]         dat_sync;
  logic               sclk;
  logic               sdat;
  logic [IW-1:0]      idle_cnt;
  logic [PW-1:0]      ph_cnt;
  logic [3:0]         bitcnt;
  logic [7:0]         shift;
  logic               clk_low;
  logic               dat_low;
  logic               retry_pend;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   count_next;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               half_done;
  logic               start_frame;
  logic               abort_now;

  // Lines are only ever pulled low; the released level comes from the bus pull-ups.
  assign ps2clk_ext  = clk_low ? 1'b0 : 1'bz;
  assign ps2data_ext = dat_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
    end else begin
      clk_sync <= {clk_sync[0], ps2clk_ext};
      dat_sync <= {dat_sync[0], ps2data_ext};
    end
  end

  assign sclk = clk_sync[1];
  assign sdat = dat_sync[1];

  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic v;
    v = 1'b1;
    case (idx)
      4'd0:    v = 1'b0;
      4'd9:    v = ~^b;
      4'd10:   v = 1'b1;
      default: v = b[3'(idx - 4'd1)];
    endcase
    return v;
  endfunction

  assign half_done   = (ph_cnt == PH_LAST);
  assign start_frame = (state == WAITBUS) && sclk && sdat && (idle_cnt == IDLE_LAST);
  assign abort_now   = (state == HIGH) && half_done && !sclk;
  assign pop         = start_frame && !retry_pend;
  assign fifo_empty  = (count == '0);
  // A pop in the same cycle frees a slot, so a full FIFO still accepts then.
  assign push        = dataload && (!fifo_full || pop);
  assign busy        = (state != IDLE) || !fifo_empty;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count     <= count_next;
      fifo_full <= (count_next == CNT_FULL);
      overflow  <= dataload && !push;
    end
  end

`ifdef PS2DEV_RETRY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              retry_pend <= 1'b0;
    else if (abort_now)   retry_pend <= 1'b1;
    else if (start_frame) retry_pend <= 1'b0;
  end
`else
  assign retry_pend = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idle_cnt <= '0;
      ph_cnt   <= '0;
      bitcnt   <= '0;
      shift    <= '0;
      clk_low  <= 1'b0;
      dat_low  <= 1'b0;
      sent     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      sent    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty || retry_pend) begin
            idle_cnt <= '0;
            state    <= WAITBUS;
          end
        end
        WAITBUS: begin
          // Any low level (inhibit or request-to-send) restarts the quiet-bus count.
          if (sclk && sdat) begin
            if (start_frame) begin
              if (!retry_pend) shift <= mem[rd_ptr];
              bitcnt  <= '0;
              ph_cnt  <= '0;
              dat_low <= 1'b1;
              state   <= HIGH;
            end else begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        HIGH: begin
          if (half_done) begin
            ph_cnt <= '0;
            if (abort_now) begin
              dat_low <= 1'b0;
              aborted <= 1'b1;
              state   <= IDLE;
            end else begin
              clk_low <= 1'b1;
              state   <= LOW;
            end
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        LOW: begin
          if (half_done) begin
            ph_cnt  <= '0;
            clk_low <= 1'b0;
            if (bitcnt == 4'd10) begin
              dat_low <= 1'b0;
              sent    <= 1'b1;
              state   <= IDLE;
            end else begin
              bitcnt  <= bitcnt + 1'b1;
              dat_low <= !frame_bit(shift, bitcnt + 4'd1);
              state   <= HIGH;
            end
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: pull-up host model sampling data on device clock falls, scoreboarded frames.
module tb_ps2_device_tx;
  localparam int HP = 8;
  localparam int IC = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data = 8'h00;
  logic       dataload = 1'b0;
  logic       host_clk_low = 1'b0;
  logic       host_dat_low = 1'b0;
  logic       busy, fifo_full, sent, aborted, overflow;
  wire        ps2clk, ps2dat;

  pullup (ps2clk);
  pullup (ps2dat);
  assign ps2clk = host_clk_low ? 1'b0 : 1'bz;
  assign ps2dat = host_dat_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  ps2_device_tx #(.HALF_PERIOD(HP), .IDLE_CYCLES(IC), .FIFO_AW(2)) dut (
    .clk(clk), .rst(rst), .data(data), .dataload(dataload),
    .ps2clk_ext(ps2clk), .ps2data_ext(ps2dat),
    .busy(busy), .fifo_full(fifo_full), .sent(sent), .aborted(aborted), .overflow(overflow)
  );

  int checks = 0;
  int errors = 0;
  logic [10:0] rx_q[$];
  logic [7:0]  exp_q[$];
  int          gap_q[$];
  int sent_cnt = 0, abort_cnt = 0, ovf_cnt = 0, edge_cnt = 0;
  int nbits = 0, since_edge = 1000, cur_run = 0, last_run = 0;
  logic [10:0] fr = '0;
  logic        prev_clk = 1'b1;

  // Host model: collects bits on device-driven clock falls; a long silence starts a new frame.
  always @(negedge clk) begin
    if (sent)     sent_cnt++;
    if (aborted)  abort_cnt++;
    if (overflow) ovf_cnt++;
    if (ps2clk === 1'b1 && ps2dat === 1'b1) cur_run++;
    else if (cur_run > 0) begin last_run = cur_run; cur_run = 0; end
    since_edge++;
    if (prev_clk && ps2clk === 1'b0 && !host_clk_low) begin
      if (since_edge > 3*HP) begin nbits = 0; gap_q.push_back(last_run); end
      fr = {ps2dat === 1'b1, fr[10:1]};
      nbits++;
      edge_cnt++;
      since_edge = 0;
      if (nbits == 11) begin rx_q.push_back(fr); nbits = 0; end
    end
    prev_clk = (ps2clk !== 1'b0);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [7:0] b);
    data = b; dataload = 1'b1; tick(); dataload = 1'b0;
    exp_q.push_back(b);
  endtask

  task automatic check_frame(input string tag, output logic [10:0] f);
    logic [7:0] b;
    int n = 0;
    f = '0;
    while (rx_q.size() == 0 && n < 2000) begin tick(); n++; end
    if (rx_q.size() == 0) begin chk({tag, "_timeout"}, rx_q.size(), 1); return; end
    f = rx_q.pop_front();
    if (exp_q.size() == 0) begin chk({tag, "_unexpected"}, exp_q.size(), 1); return; end
    b = exp_q.pop_front();
    chk(tag, f, {1'b1, ~^b, b, 1'b0});
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin tick(); n++; end
    chk(tag, busy, 0);
    tick(); tick();
  endtask

  task automatic wait_nbits(input string tag, input int k);
    int n = 0;
    while (nbits != k && n < 2000) begin tick(); n++; end
    chk(tag, nbits, k);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] f;
    int s0, a0, o0, e0, n, drops;
    logic [7:0] v;
    logic got;

    // Reset state
    tick(); tick(); tick();
    chk("rst_clk", ps2clk, 1);
    chk("rst_dat", ps2dat, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", fifo_full, 0);
    chk("rst_pulses", {sent, aborted, overflow}, 0);
    rst = 1'b0;
    tick();

    // 1: single byte
    s0 = sent_cnt;
    push(8'h1C);
    check_frame("t1_frame", f);
    chk("t1_bits", f, 11'b10000111000);
    wait_idle("t1_idle");
    chk("t1_sent", sent_cnt - s0, 1);

    // 2: back-to-back bytes, inter-frame gap
    s0 = sent_cnt;
    gap_q.delete();
    push(8'hF0);
    push(8'h00);
    check_frame("t2_f0", f);
    check_frame("t2_00", f);
    wait_idle("t2_idle");
    chk("t2_gap", 32'(gap_q.size() == 2 && gap_q[1] >= IC), 1);
    chk("t2_sent", sent_cnt - s0, 2);

    // 3: host inhibit during the 4th high phase
    s0 = sent_cnt;
    a0 = abort_cnt;
    push(8'h5A);
    push(8'h33);
    wait_nbits("t3_bit3", 3);
    n = 0;
    while (ps2clk !== 1'b1 && n < 100) begin tick(); n++; end
    tick(); tick();
    host_clk_low = 1'b1;
    n = 0;
    while (abort_cnt == a0 && n < 40) begin tick(); n++; end
    chk("t3_abort", abort_cnt - a0, 1);
    chk("t3_dat_rel", ps2dat, 1);
    repeat (30) tick();
    chk("t3_no_frame", rx_q.size(), 0);
    host_clk_low = 1'b0;
`ifdef PS2DEV_RETRY_EN
    check_frame("t3_retry", f);
`else
    void'(exp_q.pop_front());
`endif
    check_frame("t3_next", f);
    wait_idle("t3_idle");
`ifdef PS2DEV_RETRY_EN
    chk("t3_sent", sent_cnt - s0, 2);
`else
    chk("t3_sent", sent_cnt - s0, 1);
`endif

    // 4: host request-to-send holds data low
    host_dat_low = 1'b1;
    e0 = edge_cnt;
    push(8'hA5);
    repeat (100) tick();
    chk("t4_hold_edges", edge_cnt - e0, 0);
    chk("t4_busy", busy, 1);
    gap_q.delete();
    host_dat_low = 1'b0;
    check_frame("t4_frame", f);
    chk("t4_gap", 32'(gap_q.size() >= 1 && gap_q[0] >= IC), 1);
    wait_idle("t4_idle");

    // 5: overflow, then a push coinciding with the pop of a full FIFO
    o0 = ovf_cnt;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    chk("t5_full", fifo_full, 1);
    data = 8'h05; dataload = 1'b1; tick(); dataload = 1'b0;
    chk("t5_ovf", overflow, 1);
    drops = 1;
    v = 8'h40;
    got = 1'b0;
    n = 0;
    data = v; dataload = 1'b1;
    while (!got && n < 100) begin
      tick(); n++;
      if (ps2dat === 1'b0) begin
        got = 1'b1;
        chk("t5_pop_accept", overflow, 0);
        exp_q.push_back(v);
      end else begin
        drops++;
        v = v + 8'h01;
        data = v;
      end
    end
    dataload = 1'b0;
    chk("t5_pop_seen", got, 1);
    for (int i = 0; i < 5; i++) check_frame($sformatf("t5_frame%0d", i), f);
    wait_idle("t5_idle");
    chk("t5_ovf_cnt", ovf_cnt - o0, drops);

    // 6: reset mid-frame at bit 5
    push(8'h66);
    push(8'h11);
    wait_nbits("t6_bit5", 5);
    chk("t6_clk_low", ps2clk, 0);
    rst = 1'b1;
    #1;
    chk("t6_clk_rel", ps2clk, 1);
    chk("t6_dat_rel", ps2dat, 1);
    chk("t6_busy", busy, 0);
    chk("t6_full", fifo_full, 0);
    exp_q.delete();
    tick(); tick();
    rst = 1'b0;
    s0 = sent_cnt;
    e0 = edge_cnt;
    repeat (300) tick();
    chk("t6_no_edges", edge_cnt - e0, 0);
    chk("t6_no_frames", rx_q.size(), 0);
    chk("t6_no_sent", sent_cnt - s0, 0);
    chk("t6_busy_after", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
